// File: rtl/audio_sample_recorder.sv
// Capture path: drains the audio-in FIFO while recording, mixes L+R, decimates and writes words to RAM.
// Optional REC_AVERAGE_EN: boxcar-average each decimation group instead of picking its last sample.
module audio_sample_recorder #(
    parameter int unsigned SAMPLE_W = 5,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DEPTH    = 9000,
    parameter int unsigned DECIM    = 8
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [SAMPLE_W-1:0] mem_data,
    output logic                mem_wren,
    output logic                recording,
    output logic                done,
    output logic [ADDR_W-1:0]   rec_length
);
    localparam int unsigned LOG2D = $clog2(DECIM);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE} state_t;

    state_t              state_q;
    logic [LOG2D-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rec_length_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [SAMPLE_W-1:0] mem_data_q;
    logic                mem_wren_q;
    logic                recording_q;
    logic                done_q;

    logic                accept;
    logic                word_evt;
    logic                last_word;
    logic signed [32:0]  mix_full;
    logic [31:0]         mix;
    logic [SAMPLE_W-1:0] word;

    assign read_audio_in = audio_in_available & (state_q == S_REC);
    assign accept        = read_audio_in;

    // 33-bit sum halved back into 32 bits cannot overflow
    assign mix_full  = ($signed({left_channel_audio_in[31], left_channel_audio_in})
                      + $signed({right_channel_audio_in[31], right_channel_audio_in})) >>> 1;
    assign mix       = mix_full[31:0];
    assign word_evt  = accept && (cnt_q == LOG2D'(DECIM - 1));
    assign last_word = (addr_q == ADDR_W'(DEPTH - 1));

`ifdef REC_AVERAGE_EN
    localparam int unsigned ACC_W = 32 + LOG2D;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_avg;
    logic                    unused_bits;

    assign acc_sum     = acc_q + $signed({{LOG2D{mix[31]}}, mix});
    assign acc_avg     = acc_sum >>> LOG2D;
    assign word        = acc_avg[SAMPLE_W+23:24];
    assign unused_bits = ^{mix_full[32], acc_avg};
`else
    logic unused_bits;

    assign word        = mix[SAMPLE_W+23:24];
    assign unused_bits = ^{mix_full[32], mix};
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            rec_length_q  <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            recording_q   <= 1'b0;
            done_q        <= 1'b0;
`ifdef REC_AVERAGE_EN
            acc_q         <= '0;
`endif
        end else begin
            mem_wren_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !stop) begin
                        state_q      <= S_REC;
                        recording_q  <= 1'b1;
                        done_q       <= 1'b0;
                        cnt_q        <= '0;
                        addr_q       <= '0;
                        rec_length_q <= '0;
`ifdef REC_AVERAGE_EN
                        acc_q        <= '0;
`endif
                    end
                end
                S_REC: begin
                    if (accept) begin
                        cnt_q <= word_evt ? '0 : cnt_q + 1'b1;
`ifdef REC_AVERAGE_EN
                        acc_q <= word_evt ? '0 : acc_sum;
`endif
                    end
                    // a word event on the same edge as stop is still written
                    if (word_evt) begin
                        mem_wren_q    <= 1'b1;
                        mem_address_q <= addr_q;
                        mem_data_q    <= word;
                        addr_q        <= addr_q + 1'b1;
                        rec_length_q  <= addr_q + 1'b1;
                    end
                    if (stop || (word_evt && last_word)) begin
                        state_q     <= S_DONE;
                        recording_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    recording_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign recording   = recording_q;
    assign done        = done_q;
    assign rec_length  = rec_length_q;

endmodule

// File: tb/tb_audio_sample_recorder.sv
// Directed bench for audio_sample_recorder (DEPTH=4, DECIM=8) with hand-computed expectations.
module tb_audio_sample_recorder;
    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned SAMPLE_W = 5;

    logic                CLOCK_50 = 1'b0;
    logic                resetn;
    logic                start;
    logic                stop;
    logic                audio_in_available;
    logic [31:0]         left_channel_audio_in;
    logic [31:0]         right_channel_audio_in;
    logic                read_audio_in;
    logic [ADDR_W-1:0]   mem_address;
    logic [SAMPLE_W-1:0] mem_data;
    logic                mem_wren;
    logic                recording;
    logic                done;
    logic [ADDR_W-1:0]   rec_length;

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int wr_base;

    audio_sample_recorder #(
        .SAMPLE_W(SAMPLE_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (4),
        .DECIM   (8)
    ) dut (
        .CLOCK_50              (CLOCK_50),
        .resetn                (resetn),
        .start                 (start),
        .stop                  (stop),
        .audio_in_available    (audio_in_available),
        .left_channel_audio_in (left_channel_audio_in),
        .right_channel_audio_in(right_channel_audio_in),
        .read_audio_in         (read_audio_in),
        .mem_address           (mem_address),
        .mem_data              (mem_data),
        .mem_wren              (mem_wren),
        .recording             (recording),
        .done                  (done),
        .rec_length            (rec_length)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // counts write pulses; sampled at the edge that closes the write cycle
    always @(posedge CLOCK_50) if (resetn && mem_wren) wr_cnt = wr_cnt + 1;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0;
        audio_in_available = 1'b1;
        left_channel_audio_in = 32'h0300_0000;
        right_channel_audio_in = 32'h0300_0000;
        steps(2);
        chk("rst_read", read_audio_in, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_rec", recording, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_len", rec_length, 0);
        resetn = 1'b1;
        step();

        // continuous capture until the 4-word recording fills
        wr_base = wr_cnt;
        start = 1'b1; step(); start = 1'b0;
        chk("rec_hi", recording, 1);
        chk("read_hi", read_audio_in, 1);
        steps(7);
        chk("no_wr_before_8", mem_wren, 0);
        step();
        chk("w0_wren", mem_wren, 1);
        chk("w0_addr", mem_address, 0);
        chk("w0_data", mem_data, 5'd3);
        steps(8);
        chk("w1_wren", mem_wren, 1);
        chk("w1_addr", mem_address, 1);
        steps(16);
        chk("w3_wren", mem_wren, 1);
        chk("w3_addr", mem_address, 3);
        chk("full_done", done, 1);
        chk("full_len", rec_length, 4);
        chk("full_read", read_audio_in, 0);
        step();
        chk("full_wren_off", mem_wren, 0);
        chk("full_wr_cnt", wr_cnt - wr_base, 4);
        chk("full_addr_hold", mem_address, 3);

        // early stop after 19 accepts, then restart
        wr_base = wr_cnt;
        start = 1'b1; step(); start = 1'b0;
        chk("restart_rec", recording, 1);
        chk("restart_len_clr", rec_length, 0);
        steps(19);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_done", done, 1);
        chk("stop_len", rec_length, 2);
        chk("stop_read", read_audio_in, 0);
        chk("stop_wr_cnt", wr_cnt - wr_base, 2);
        start = 1'b1; step(); start = 1'b0;
        chk("again_len", rec_length, 0);
        steps(8);
        chk("again_wren", mem_wren, 1);
        chk("again_addr", mem_address, 0);

        // start+stop together: REC -> DONE, IDLE -> IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("ss_rec_done", done, 1);
        resetn = 1'b0; step(); resetn = 1'b1; step();
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("ss_idle_rec", recording, 0);
        chk("ss_idle_done", done, 0);

        // stop on the word-event edge still writes
        start = 1'b1; step(); start = 1'b0;
        steps(7);
        stop = 1'b1; step(); stop = 1'b0;
        chk("sw_wren", mem_wren, 1);
        chk("sw_addr", mem_address, 0);
        chk("sw_done", done, 1);
        chk("sw_len", rec_length, 1);

        // L = -R mixes to zero
        start = 1'b1; step(); start = 1'b0;
        left_channel_audio_in = 32'h1000_0000;
        right_channel_audio_in = 32'hF000_0000;
        steps(8);
        chk("cancel_wren", mem_wren, 1);
        chk("cancel_data", mem_data, 0);

        // alternating 0 / 0x0800_0000: average gives 4, pick gives 8
        for (int i = 0; i < 8; i++) begin
            left_channel_audio_in  = (i % 2 == 1) ? 32'h0800_0000 : 32'h0;
            right_channel_audio_in = left_channel_audio_in;
            step();
        end
        chk("alt_addr", mem_address, 1);
`ifdef REC_AVERAGE_EN
        chk("alt_data", mem_data, 5'd4);
`else
        chk("alt_data", mem_data, 5'd8);
`endif

        // negative constant: 0xFD00_0000 -> bits [28:24] = 0x1D
        left_channel_audio_in = 32'hFD00_0000;
        right_channel_audio_in = 32'hFD00_0000;
        steps(8);
        chk("neg_addr", mem_address, 2);
        chk("neg_data", mem_data, 5'h1D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
